// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 pooling over full input rows with valid/ready on both sides.
// One pool2x2_lane per output element; the top holds row phase, row buffer and output register.

module pool2x2_lane #(
  parameter int DW     = 16,
  parameter int MODE   = 0,
  parameter int SIGNED = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW:0]   buf_e,
  output logic [DW:0]   h,
  output logic [DW-1:0] res
);
  localparam logic SG = (SIGNED != 0);

  logic [DW:0] ax, bx;
  assign ax = {SG & a[DW-1], a};
  assign bx = {SG & b[DW-1], b};

  // Extended operands are non-negative when unsigned, so a signed compare serves both modes.
  function automatic logic gt(input logic [DW:0] x, input logic [DW:0] y);
    return $signed(x) > $signed(y);
  endfunction

  if (MODE == 0) begin : g_max
    always_comb begin
      h   = gt(bx, ax) ? bx : ax;
      res = DW'(gt(h, buf_e) ? h : buf_e);
    end
  end else begin : g_avg
    logic [DW+1:0] s;
    always_comb begin
      h   = ax + bx;
      s   = {SG & buf_e[DW], buf_e} + {SG & h[DW], h};
      res = SG ? DW'($signed(s) >>> 2) : DW'(s >> 2);
    end
  end
endmodule

module pool2x2_stream #(
  parameter int DW     = 16,
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int CH     = 2,
  parameter int MODE   = 0,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [CH*IN_W*DW-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH*(IN_W/2)*DW-1:0]  out_data,
  output logic                       out_last
);
  localparam int NP = CH * IN_W / 2;
  localparam int RW = $clog2(IN_H);
  localparam logic [RW-1:0] LAST = RW'(IN_H - 1);

  logic [RW-1:0]           row_q, row_d;
  logic [NP-1:0][DW:0]     buf_q, buf_d;
  logic [NP-1:0][DW-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [NP-1:0][DW:0]     h;
  logic [NP-1:0][DW-1:0]   res;
  logic                    odd, acc;

  // Output element g pools input elements 2g and 2g+1 of the same channel.
  for (genvar g = 0; g < NP; g++) begin : g_lane
    pool2x2_lane #(.DW(DW), .MODE(MODE), .SIGNED(SIGNED)) u_lane (
      .a     (in_data[(2*g)*DW +: DW]),
      .b     (in_data[(2*g+1)*DW +: DW]),
      .buf_e (buf_q[g]),
      .h     (h[g]),
      .res   (res[g])
    );
  end

  always_comb begin
    // A sof beat is always an even-phase beat, whatever the counter says.
    odd         = row_q[0] && !in_sof;
    in_ready    = !odd || !out_valid_q || out_ready;
    acc         = in_valid && in_ready;
    row_d       = row_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (acc) begin
      if (in_sof)            row_d = RW'(1);
      else if (row_q == LAST) row_d = '0;
      else                   row_d = row_q + RW'(1);
      if (odd) begin
        out_data_d  = res;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == LAST);
      end else begin
        buf_d = h;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      row_q       <= row_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench: four small 4x2 instances driven from a vector table, plus a default-size
// instance under random stimulus checked against a row-level scoreboard.

module tb_pool2x2_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- small instances: 0 max/uns, 1 max/sgn, 2 avg/uns, 3 avg/sgn
  logic        s_in_valid, s_in_sof, s_out_ready;
  logic [63:0] s_in_data;
  logic        s_in_ready [4];
  logic        s_out_valid [4];
  logic        s_out_last [4];
  logic [31:0] s_out_data [4];

  for (genvar i = 0; i < 4; i++) begin : g_small
    pool2x2_stream #(.DW(16), .IN_W(4), .IN_H(2), .CH(1), .MODE(i/2), .SIGNED(i%2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready[i]), .in_sof(s_in_sof), .in_data(s_in_data),
      .out_valid(s_out_valid[i]), .out_ready(s_out_ready), .out_data(s_out_data[i]),
      .out_last(s_out_last[i])
    );
  end

  // ---------------- default-size instance
  logic         e_in_valid, e_in_ready, e_in_sof, e_out_valid, e_out_ready, e_out_last;
  logic [895:0] e_in_data;
  logic [447:0] e_out_data;

  pool2x2_stream u_big (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_sof(e_in_sof), .in_data(e_in_data),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .out_last(e_out_last)
  );

  // ---------------- reference model
  function automatic longint ev(input logic [15:0] x, input int sgn);
    if (sgn != 0) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic logic [447:0] ref_pool(input logic [895:0] r0, input logic [895:0] r1,
                                            input int w, input int ch, input int mode, input int sgn);
    logic [447:0] o;
    longint v [4];
    longint m, s;
    o = '0;
    for (int c = 0; c < ch; c++)
      for (int k = 0; k < w/2; k++) begin
        v[0] = ev(r0[(c*w+2*k)*16 +: 16], sgn);
        v[1] = ev(r0[(c*w+2*k+1)*16 +: 16], sgn);
        v[2] = ev(r1[(c*w+2*k)*16 +: 16], sgn);
        v[3] = ev(r1[(c*w+2*k+1)*16 +: 16], sgn);
        if (mode == 0) begin
          m = v[0];
          for (int q = 1; q < 4; q++) if (v[q] > m) m = v[q];
        end else begin
          s = v[0] + v[1] + v[2] + v[3];
          m = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end
        o[(c*w/2+k)*16 +: 16] = m[15:0];
      end
    return o;
  endfunction

  // ---------------- scoreboard for the default-size instance
  logic [447:0] exp_q [$];
  logic         last_q [$];
  logic [895:0] buf_row;
  int           mrow = 0, n_out = 0, n_last = 0, blocked_cnt = 0;
  logic         stall_prev = 1'b0, prev_last;
  logic [447:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); last_q.delete();
      mrow = 0; stall_prev = 1'b0;
    end else begin
      logic odd;
      if (stall_prev) begin
        chk("hold_valid", e_out_valid, 1'b1);
        chk("hold_data", e_out_data, prev_data);
        chk("hold_last", e_out_last, prev_last);
      end
      if (e_out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", e_out_valid, 1'b0);
        else if (e_out_ready) begin
          chk("out_data", e_out_data, exp_q.pop_front());
          chk("out_last", e_out_last, last_q.pop_front());
          n_out++;
          if (e_out_last) n_last++;
        end
      end
      stall_prev = e_out_valid && !e_out_ready;
      prev_data  = e_out_data;
      prev_last  = e_out_last;

      odd = (mrow % 2 == 1) && !e_in_sof;
      chk("in_ready", e_in_ready, !odd || !e_out_valid || e_out_ready);
      if (e_in_valid && !e_in_ready) blocked_cnt++;
      if (e_in_valid && e_in_ready) begin
        if (odd) begin
          exp_q.push_back(ref_pool(buf_row, e_in_data, 28, 2, 0, 0));
          last_q.push_back(mrow == 27);
        end else buf_row = e_in_data;
        mrow = e_in_sof ? 1 : (mrow + 1) % 28;
      end
    end
  end

  // ---------------- downstream ready driver
  int   stall_cnt = 0;
  logic rdy_rand = 1'b0;
  always @(posedge clk) begin
    #2;
    if (stall_cnt > 0) begin
      e_out_ready = 1'b0;
      stall_cnt--;
    end else e_out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
  end

  function automatic logic [895:0] rand_row();
    logic [895:0] r;
    for (int i = 0; i < 28; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] row4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic send_row(input logic [895:0] d, input logic sof);
    int t;
    logic acc;
    e_in_valid = 1'b1; e_in_sof = sof; e_in_data = d;
    t = 0;
    do begin
      @(negedge clk); acc = e_in_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", acc, 1'b1);
    e_in_valid = 1'b0; e_in_sof = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0]       r0, r1;
    logic [3:0][31:0]  exp;
  } vec_t;
  vec_t tv [8];

  initial begin
    rst = 1'b1;
    s_in_valid = 0; s_in_sof = 0; s_in_data = '0; s_out_ready = 1'b1;
    e_in_valid = 0; e_in_sof = 0; e_in_data = '0; e_out_ready = 1'b1;

    tv[0].r0 = row4(1, 5, 2, 3);  tv[0].r1 = row4(4, 0, 9, 1);
    tv[0].exp[0] = {16'd9, 16'd5}; tv[0].exp[1] = {16'd9, 16'd5};
    tv[0].exp[2] = {16'd3, 16'd2}; tv[0].exp[3] = {16'd3, 16'd2};
    tv[1].r0 = row4(16'hFFFF, 16'h0001, 16'h8000, 16'hFFFE);
    tv[1].r1 = row4(16'hFFFE, 16'hFFFD, 16'h8001, 16'h8000);
    tv[1].exp[0] = {16'hFFFE, 16'hFFFF}; tv[1].exp[1] = {16'hFFFE, 16'h0001};
    tv[1].exp[2] = {16'h9FFF, 16'hBFFE}; tv[1].exp[3] = {16'h9FFF, 16'hFFFE};
    tv[2].r0 = row4(16'hFFFF, 16'hFFFE, 16'd3, 16'd3);
    tv[2].r1 = row4(16'hFFFD, 16'hFFFD, 16'd3, 16'd2);
    tv[2].exp[0] = {16'd3, 16'hFFFF}; tv[2].exp[1] = {16'd3, 16'hFFFF};
    tv[2].exp[2] = {16'd2, 16'hFFFD}; tv[2].exp[3] = {16'd2, 16'hFFFD};
    for (int v = 3; v < 8; v++) begin
      logic [447:0] e;
      tv[v].r0 = {$urandom, $urandom};
      tv[v].r1 = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        e = ref_pool({832'b0, tv[v].r0}, {832'b0, tv[v].r1}, 4, 1, i/2, i%2);
        tv[v].exp[i] = e[31:0];
      end
    end

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", e_out_valid, 1'b0);
    chk("rst_out_last", e_out_last, 1'b0);
    chk("rst_out_data", e_out_data, '0);
    chk("rst_in_ready", e_in_ready, 1'b1);
    chk("rst_small_valid", s_out_valid[0], 1'b0);
    @(posedge clk); #1;

    // small instances: two rows per vector, output one cycle after the second accept
    for (int v = 0; v < 8; v++) begin
      s_in_valid = 1'b1; s_in_sof = 1'b1; s_in_data = tv[v].r0;
      @(posedge clk); #1;
      s_in_sof = 1'b0; s_in_data = tv[v].r1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("v%0d_early_valid_%0d", v, i), s_out_valid[i], 1'b0);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("v%0d_valid_%0d", v, i), s_out_valid[i], 1'b1);
        chk($sformatf("v%0d_last_%0d", v, i), s_out_last[i], 1'b1);
        chk($sformatf("v%0d_data_%0d", v, i), s_out_data[i], tv[v].exp[i]);
      end
      @(posedge clk); #1;
    end

    // full frame, downstream stalls 5 cycles after the first output
    n_out = 0; n_last = 0; blocked_cnt = 0;
    for (int r = 0; r < 28; r++) begin
      send_row(rand_row(), r == 0);
      if (r == 1) stall_cnt = 5;
    end
    drain();
    chk("bp_in_ready_low", blocked_cnt > 0, 1'b1);
    chk("frame_outputs", n_out, 14);
    chk("frame_lasts", n_last, 1);

    // sof on row 5 (odd phase) restarts the frame; random gaps and random ready
    n_out = 0; n_last = 0; rdy_rand = 1'b1;
    for (int r = 0; r < 33; r++) begin
      send_row(rand_row(), r == 0 || r == 5);
      if ($urandom % 4 == 0) idle(1 + $urandom % 3);
    end
    drain();
    chk("sof_outputs", n_out, 16);
    chk("sof_lasts", n_last, 1);

    // reset while an output is pending
    rdy_rand = 1'b0; stall_cnt = 1000;
    send_row(rand_row(), 1'b1);
    send_row(rand_row(), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", e_out_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; stall_cnt = 0;
    @(negedge clk);
    chk("post_rst_valid", e_out_valid, 1'b0);
    chk("post_rst_data", e_out_data, '0);
    @(posedge clk); #1;
    n_out = 0; n_last = 0;
    send_row(rand_row(), 1'b0);
    send_row(rand_row(), 1'b0);
    drain();
    chk("post_rst_outputs", n_out, 1);

    // three back-to-back frames under random backpressure
    n_out = 0; n_last = 0; rdy_rand = 1'b1;
    idle(2);
    for (int r = 0; r < 84; r++) send_row(rand_row(), r == 0);
    drain();
    chk("multi_outputs", n_out, 42);
    chk("multi_lasts", n_last, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
